fifo_rd_ctrl: RTL and testbench

Read-side controller that sits directly downstream of the 16-bit × 8 synchronous FIFO. It issues `fifo_rd_en` only when a read is safe, absorbs the FIFO's one-cycle read latency, and re-presents the words on a valid/ready stream through a small elastic buffer. A consumer can apply backpressure without ever causing FIFO underflow or losing a word. It also keeps a delivered-word counter and a sticky underflow error flag.

---
 rtl/fifo_rd_ctrl_if.sv | 12 +
 rtl/fifo_rd_ctrl.sv | 109 ++++++++++
 tb/tb_fifo_rd_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// Valid/ready word stream between the FIFO read controller and its consumer.
// The producer drives valid/data; the consumer drives ready.
interface fifo_rd_ctrl_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_rd_ctrl.sv
// FIFO read controller: issues safe reads and absorbs the 1-cycle read latency into an elastic buffer.
// First word appears 2 cycles after fifo_rd_en. Optional FIFO_RD_BURST_EN adds an almost-full/flush burst FSM.
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic                  fifo_almostfull,
  input  logic                  fifo_full,
  input  logic                  fifo_underflow,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  fifo_rd_ctrl_if.master        m,
  output logic [15:0]           word_count,
  output logic                  err_underflow
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [PW-1:0] LAST    = PW'(BUF_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         occ;
  logic                  inflight;
  logic                  state_ok;
  logic                  pop;
  logic [CW:0]           pending;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Only registered occupancy feeds the read decision, so m_ready never reaches fifo_rd_en.
  assign pending    = {1'b0, occ} + {{CW{1'b0}}, inflight};
  assign fifo_rd_en = rst_n & enable & ~fifo_empty & (pending < DEPTH_W) & state_ok;

  assign m.valid = (occ != '0);
  assign m.data  = mem[head];
  assign pop     = m.valid & m.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      inflight <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight) begin
        mem[tail] <= fifo_data_out;
        tail      <= ptr_next(tail);
      end
      if (pop) head <= ptr_next(head);
      case ({inflight, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count    <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (pop) word_count <= word_count + 16'd1;
      if (fifo_underflow) err_underflow <= 1'b1;
    end
  end

`ifdef FIFO_RD_BURST_EN
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stay in BURST until the FIFO is dry and the last read has landed; flush pins it there.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fifo_almostfull | fifo_full | flush) state_nxt = BURST;
      BURST:   if (fifo_empty & ~inflight & ~flush) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    state_ok = (state == BURST);
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{flush, fifo_almostfull, fifo_full};
  assign state_ok   = 1'b1;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural 16x8 FIFO upstream, scoreboard queue checked by a negedge monitor.
module tb_fifo_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        flush;
  logic        wr_en;
  logic [15:0] wr_din;
  logic        uf_inject;

  logic [15:0] fmem [8];
  logic [2:0]  wp;
  logic [2:0]  rp;
  logic [3:0]  cnt;
  logic [15:0] fifo_dout;
  logic        model_uf;
  logic        fifo_empty;
  logic        fifo_almostfull;
  logic        fifo_full;
  logic        fifo_rd_en;
  logic        do_wr;
  logic        do_rd;
  logic [15:0] word_count;
  logic        err_underflow;

  fifo_rd_ctrl_if #(.DATA_WIDTH(16)) m_if ();

  fifo_rd_ctrl #(.DATA_WIDTH(16), .BUF_DEPTH(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .flush           (flush),
    .fifo_empty      (fifo_empty),
    .fifo_almostfull (fifo_almostfull),
    .fifo_full       (fifo_full),
    .fifo_underflow  (model_uf | uf_inject),
    .fifo_data_out   (fifo_dout),
    .fifo_rd_en      (fifo_rd_en),
    .m               (m_if),
    .word_count      (word_count),
    .err_underflow   (err_underflow)
  );

  always #5 clk = ~clk;

  // Upstream synchronous FIFO model, same reset as the controller
  assign fifo_empty      = (cnt == 4'd0);
  assign fifo_almostfull = (cnt == 4'd7);
  assign fifo_full       = (cnt == 4'd8);
  assign do_wr           = wr_en && (cnt != 4'd8);
  assign do_rd           = fifo_rd_en && (cnt != 4'd0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0; rp <= '0; cnt <= '0; fifo_dout <= '0; model_uf <= 1'b0;
    end else begin
      model_uf <= fifo_rd_en && (cnt == 4'd0);
      if (do_wr) begin
        fmem[wp] <= wr_din;
        wp       <= wp + 3'd1;
      end
      if (do_rd) begin
        fifo_dout <= fmem[rp];
        rp        <= rp + 3'd1;
      end
      cnt <= cnt + {3'b0, do_wr} - {3'b0, do_rd};
    end
  end

  int          nvec = 0;
  int          nerr = 0;
  logic [15:0] exp_q [$];
  int          rd_cnt = 0;
  logic        uf_seen = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  int          base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: handshake seen at negedge completes at the next posedge
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) chk("hold_stable", m_if.data, prev_data);
      if (m_if.valid && m_if.ready) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_word: got 0x%0h expected no word", m_if.data);
        end else begin
          chk("order", m_if.data, exp_q.pop_front());
        end
      end
      if (fifo_rd_en) rd_cnt++;
      if (model_uf) uf_seen = 1'b1;
      prev_stall = m_if.valid && !m_if.ready;
      prev_data  = m_if.data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] d);
    wr_en  = 1'b1;
    wr_din = d;
    exp_q.push_back(d);
    tick();
    wr_en  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_din = '0;
    uf_inject = 1'b0; m_if.ready = 1'b0;
    #3;
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", m_if.valid, 0);
    chk("rst_data", m_if.data, 0);
    chk("rst_count", word_count, 0);
    chk("rst_err", err_underflow, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

`ifdef FIFO_RD_BURST_EN
    enable = 1'b1; m_if.ready = 1'b1;
    base = rd_cnt;
    for (int i = 1; i <= 6; i++) wr(16'hE000 + 16'(i));
    repeat (4) tick();
    chk("burst_idle_reads", rd_cnt - base, 0);
    wr(16'hE007);
    repeat (14) tick();
    chk("burst_reads", rd_cnt - base, 7);
    chk("burst_count", word_count, 7);
    chk("burst_drained", m_if.valid, 0);
    wr(16'hE101); wr(16'hE102);
    repeat (3) tick();
    chk("burst_wait_flush", rd_cnt - base, 7);
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (8) tick();
    chk("flush_reads", rd_cnt - base, 9);
    chk("flush_count", word_count, 9);
    chk("burst_err", err_underflow, 0);
`else
    // Streaming: preload 5 words with reads disabled, then release
    m_if.ready = 1'b1;
    for (int i = 1; i <= 5; i++) wr(16'hA000 + 16'(i));
    chk("no_rd_when_disabled", fifo_rd_en, 0);
    enable = 1'b1;
    #1;
    chk("first_rd", fifo_rd_en, 1);
    tick();
    chk("latency_c1_valid", m_if.valid, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stream_valid", m_if.valid, 1);
      tick();
    end
    chk("stream_end_valid", m_if.valid, 0);
    chk("stream_count", word_count, 5);

    // Backpressure: 8 words, consumer stalled
    enable = 1'b0; m_if.ready = 1'b0;
    for (int i = 1; i <= 8; i++) wr(16'hB000 + 16'(i));
    base = rd_cnt;
    enable = 1'b1;
    repeat (10) tick();
    chk("bp_reads", rd_cnt - base, 3);
    chk("bp_rd_idle", fifo_rd_en, 0);
    chk("bp_valid", m_if.valid, 1);
    chk("bp_head", m_if.data, 16'hB001);
    m_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("bp_drain_valid", m_if.valid, 1);
      tick();
    end
    chk("bp_end_valid", m_if.valid, 0);
    chk("bp_count", word_count, 13);

    // Single word
    base = rd_cnt;
    wr(16'hC001);
    repeat (6) tick();
    chk("single_reads", rd_cnt - base, 1);
    chk("single_fifo_uf", uf_seen, 0);
    chk("single_err", err_underflow, 0);
    chk("single_count", word_count, 14);

    // Sticky underflow error
    uf_inject = 1'b1; tick(); uf_inject = 1'b0;
    chk("err_set", err_underflow, 1);
    repeat (3) tick();
    chk("err_sticky", err_underflow, 1);

    // Mid-stream reset with two words buffered
    m_if.ready = 1'b0;
    wr(16'hD001); wr(16'hD002);
    repeat (4) tick();
    chk("pre_rst_valid", m_if.valid, 1);
    chk("pre_rst_head", m_if.data, 16'hD001);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mrst_valid", m_if.valid, 0);
    chk("mrst_data", m_if.data, 0);
    chk("mrst_rd_en", fifo_rd_en, 0);
    chk("mrst_count", word_count, 0);
    chk("mrst_err", err_underflow, 0);
    tick();
    rst_n = 1'b1;
    m_if.ready = 1'b1;
    repeat (5) tick();
    chk("post_rst_valid", m_if.valid, 0);
    chk("post_rst_count", word_count, 0);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
